lstm_cell_update: RTL and testbench
===================================

LSTM_CELL_UPDATE -- requirements
Module: lstm_cell_update

Interface
REQ-001 SHALL have parameter D_WL, default 16: data word length, two's complement.
REQ-002 SHALL have parameter FL, default 12: fractional bits; 1.0 = 2^FL.
REQ-003 SHALL have parameter HIDDEN, default 32, range 1..256: hidden units per timestep.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port d_in, input, D_WL: raw gate pre-activation from the upstream PE d_o.
REQ-007 SHALL have port in_valid, input, 1: d_in valid this cycle, driven from PE o_valid; single-cycle pulses or continuous.
REQ-008 SHALL have port clear_state, input, 1: synchronous start-of-sequence clear.
REQ-009 SHALL have port h_o, output, D_WL: hidden output h.
REQ-010 SHALL have port c_o, output, D_WL: updated cell state c.
REQ-011 SHALL have port h_idx, output, 8: hidden-unit index of h_o/c_o.
REQ-012 SHALL have port o_valid, output, 1: h_o, c_o and h_idx valid; one-cycle pulse per unit.
REQ-013 SHALL have port seq_done, output, 1: asserted together with o_valid when h_idx == HIDDEN-1.

Function
REQ-014 SHALL keep gate counter gsel (0=i, 1=f, 2=g, 3=o).
- gsel advances on each accepted in_valid; wraps 3->0.
REQ-015 SHALL keep unit counter uidx.
- Advances on accepted in_valid when gsel==3; wraps HIDDEN-1->0.
REQ-016 SHALL apply hard-sigmoid to gates i, f and o: y = (x>>>2) + 2^(FL-1), clamped to [0, 2^FL].
REQ-017 SHALL apply hard-tanh to gate g: y = x clamped to [-2^FL, 2^FL].
REQ-018 SHALL register activated i, f and g on acceptance.
- Registers hold their value until overwritten.
REQ-019 SHALL, at edge k when the o gate is accepted, capture into stage 1:
- act(o), i, f, g, c_mem[uidx] and uidx.
REQ-020 SHALL, at edge k+1, compute c_new = sat((f*c_prev + i*g) >>> FL).
- Products and sum use full 2*D_WL+1 width.
- sat clamps to [-2^(D_WL-1), 2^(D_WL-1)-1].
- c_new is written to c_mem[idx] at the same edge.
REQ-021 SHALL, at edge k+2, register h_o = (o * hardtanh(c_new)) >>>FL, truncated to D_WL.
- Same edge also registers c_o = c_new, h_idx, o_valid=1 and seq_done.
REQ-022 SHALL give a fixed latency of o_valid high in exactly the cycle after edge k+2, with no stall and no backpressure.
REQ-023 SHALL hold h_o, c_o and h_idx between pulses; o_valid and seq_done otherwise 0.
REQ-024 SHALL hold c_mem as HIDDEN x D_WL storage.
- The write at k+1 precedes any read of the same index; minimum spacing is 4 accepted inputs.
REQ-025 SHALL, on clear_state high at an edge:
- zero all of c_mem, gsel and uidx;
- flush stage valids, so no o_valid results from in-flight units;
- discard in_valid in that cycle.
- clear_state has priority over everything except rst.

Reset
REQ-026 SHALL, while rst is high (asynchronously), hold:
- h_o=0, c_o=0, h_idx=0, o_valid=0, seq_done=0;
- gsel=0, uidx=0, all stage valids 0, c_mem all 0, gate registers 0.
REQ-027 SHALL, on reset mid-pipeline, drop in-flight units; no o_valid after release until 4 new gates are accepted.

Verification
REQ-028 SHALL cover unit 0 from reset with FL=12:
- Stimulus: gates i=0x7FFF, f=0x0000, g=0x1000, o=0x7FFF.
- Response: o_valid 3 cycles after the o gate; c_o=4096, h_o=4096, h_idx=0.
REQ-029 SHALL cover state carry with HIDDEN=2:
- Stimulus: unit0 as REQ-028, unit1 all zeros, then unit0 again with f=0x7FFF.
- Response: unit1 c_o=0, h_o=0; second unit0 c_o=8192, h_o=4096.
- seq_done=1 on the unit1 output only.
REQ-030 SHALL cover saturation:
- Stimulus: c_mem[0] preloaded to -30000 via prior units; then i=f=0x7FFF, g=0x8000, o=0x7FFF.
- Response: c_o=0x8000 (-32768), h_o=-4096.
REQ-031 SHALL cover clear_state:
- Stimulus: clear_state pulsed after 2 of 4 gates, then 4 fresh gates.
- Response: exactly one o_valid, h_idx=0, c_prev treated as 0.
REQ-032 SHALL cover reset mid-pipeline:
- Stimulus: rst asserted for 1 cycle at edge k+1 after an o gate.
- Response: o_valid stays 0; all outputs 0; next unit reports h_idx=0.
REQ-033 SHALL cover back-to-back traffic:
- Stimulus: continuous in_valid for 4*HIDDEN cycles.
- Response: o_valid every 4th cycle; h_idx 0..HIDDEN-1 in order; single seq_done; wrap back to 0.

Source files
------------

// File: rtl/lstm_cell_update.sv
// LSTM cell-state/hidden update: activates the four serial gate words per hidden unit,
// updates the per-unit cell memory and emits h/c three cycles after the o gate.
module lstm_cell_update #(
  parameter int D_WL   = 16,
  parameter int FL     = 12,
  parameter int HIDDEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [D_WL-1:0] d_in,
  input  logic                   in_valid,
  input  logic                   clear_state,
  output logic signed [D_WL-1:0] h_o,
  output logic signed [D_WL-1:0] c_o,
  output logic [7:0]             h_idx,
  output logic                   o_valid,
  output logic                   seq_done
);

  localparam int UW  = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
  localparam int P_W = 2*D_WL + 1;

  localparam logic signed [D_WL+1:0] SIG_HALF = (D_WL+2)'(64'sd1 <<< (FL-1));
  localparam logic signed [D_WL+1:0] SIG_ONE  = (D_WL+2)'(64'sd1 <<< FL);
  localparam logic signed [D_WL-1:0] ACT_ONE  = D_WL'(64'sd1 <<< FL);
  localparam logic signed [D_WL-1:0] ACT_NEG  = D_WL'(-(64'sd1 <<< FL));
  localparam logic signed [P_W-1:0]  C_MAX    = P_W'((64'sd1 <<< (D_WL-1)) - 64'sd1);
  localparam logic signed [P_W-1:0]  C_MIN    = P_W'(-(64'sd1 <<< (D_WL-1)));

  function automatic logic signed [P_W-1:0] sx(input logic signed [D_WL-1:0] x);
    return {{(P_W-D_WL){x[D_WL-1]}}, x};
  endfunction

  function automatic logic signed [D_WL-1:0] hard_sigmoid(input logic signed [D_WL-1:0] x);
    logic signed [D_WL+1:0] ext;
    logic signed [D_WL+1:0] y;
    ext = {{2{x[D_WL-1]}}, x};
    y   = (ext >>> 2) + SIG_HALF;
    if (y < 0)            return '0;
    else if (y > SIG_ONE) return ACT_ONE;
    else                  return y[D_WL-1:0];
  endfunction

  function automatic logic signed [D_WL-1:0] hard_tanh(input logic signed [D_WL-1:0] x);
    if (x > ACT_ONE)      return ACT_ONE;
    else if (x < ACT_NEG) return ACT_NEG;
    else                  return x;
  endfunction

  function automatic logic signed [D_WL-1:0] sat_cell(input logic signed [P_W-1:0] x);
    if (x > C_MAX)      return C_MAX[D_WL-1:0];
    else if (x < C_MIN) return C_MIN[D_WL-1:0];
    else                return x[D_WL-1:0];
  endfunction

  // h = (o * hardtanh(c)) >>> FL, keeping only the low D_WL bits
  function automatic logic signed [D_WL-1:0] scale_h(input logic signed [D_WL-1:0] o,
                                                     input logic signed [D_WL-1:0] c);
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;
    prod    = sx(o) * sx(hard_tanh(c));
    shifted = prod >>> FL;
    return shifted[D_WL-1:0];
  endfunction

  logic [1:0]             gsel;
  logic [UW-1:0]          uidx;
  logic                   accept;
  logic signed [D_WL-1:0] act_p0;
  logic signed [D_WL-1:0] i_p0, f_p0, g_p0;

  logic signed [D_WL-1:0] o_p1, i_p1, f_p1, g_p1, c_prev_p1;
  logic [UW-1:0]          idx_p1;
  logic                   vld_p1;
  logic signed [P_W-1:0]  csum;
  logic signed [D_WL-1:0] c_new;

  logic signed [D_WL-1:0] o_p2, c_new_p2;
  logic [UW-1:0]          idx_p2;
  logic                   vld_p2;

  logic signed [D_WL-1:0] c_mem [HIDDEN];

  assign accept = in_valid & ~clear_state;
  assign act_p0 = (gsel == 2'd2) ? hard_tanh(d_in) : hard_sigmoid(d_in);
  assign csum   = sx(f_p1) * sx(c_prev_p1) + sx(i_p1) * sx(g_p1);
  assign c_new  = sat_cell(csum >>> FL);

  // p0 -> p1: o gate accepted, snapshot gates and the unit's previous cell state
  always_ff @(posedge clk) begin
    if (accept && gsel == 2'd3) begin
      o_p1      <= act_p0;
      i_p1      <= i_p0;
      f_p1      <= f_p0;
      g_p1      <= g_p0;
      c_prev_p1 <= c_mem[uidx];
      idx_p1    <= uidx;
    end
    // p1 -> p2: new cell state
    if (vld_p1) begin
      o_p2     <= o_p1;
      c_new_p2 <= c_new;
      idx_p2   <= idx_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gsel     <= '0;
      uidx     <= '0;
      i_p0     <= '0;
      f_p0     <= '0;
      g_p0     <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      h_o      <= '0;
      c_o      <= '0;
      h_idx    <= '0;
      o_valid  <= 1'b0;
      seq_done <= 1'b0;
      for (int n = 0; n < HIDDEN; n++) c_mem[n] <= '0;
    end else if (clear_state) begin
      gsel     <= '0;
      uidx     <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      o_valid  <= 1'b0;
      seq_done <= 1'b0;
      for (int n = 0; n < HIDDEN; n++) c_mem[n] <= '0;
    end else begin
      if (accept) begin
        gsel <= gsel + 2'd1;
        case (gsel)
          2'd0:    i_p0 <= act_p0;
          2'd1:    f_p0 <= act_p0;
          2'd2:    g_p0 <= act_p0;
          default: begin
            if (uidx == UW'(HIDDEN-1)) uidx <= '0;
            else                       uidx <= uidx + UW'(1);
          end
        endcase
      end
      vld_p1 <= accept && (gsel == 2'd3);
      vld_p2 <= vld_p1;
      if (vld_p1) c_mem[idx_p1] <= c_new;
      // p2 -> output
      o_valid  <= vld_p2;
      seq_done <= vld_p2 && (idx_p2 == UW'(HIDDEN-1));
      if (vld_p2) begin
        h_o   <= scale_h(o_p2, c_new_p2);
        c_o   <= c_new_p2;
        h_idx <= 8'(idx_p2);
      end
    end
  end

endmodule

// File: tb/tb_lstm_cell_update.sv
// Randomized scoreboard bench for lstm_cell_update against an arithmetic reference model.
module tb_lstm_cell_update;
  localparam int D_WL = 16;
  localparam int FL   = 12;
  localparam int HID  = 2;

  typedef struct {
    logic [15:0] h;
    logic [15:0] c;
    logic [7:0]  idx;
    logic        done;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, clear_state;
  logic [15:0] d_in;
  logic [15:0] h_o, c_o;
  logic [7:0]  h_idx;
  logic        o_valid, seq_done;

  lstm_cell_update #(.D_WL(D_WL), .FL(FL), .HIDDEN(HID)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .clear_state(clear_state),
    .h_o(h_o), .c_o(c_o), .h_idx(h_idx), .o_valid(o_valid), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  int m_c [HID];
  int m_g, m_u, m_i, m_f, m_gg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int hsig(input int x);
    int y;
    y = (x >>> 2) + (1 << (FL-1));
    if (y < 0) y = 0;
    if (y > (1 << FL)) y = 1 << FL;
    return y;
  endfunction

  function automatic int htanh(input int x);
    if (x > (1 << FL)) return 1 << FL;
    if (x < -(1 << FL)) return -(1 << FL);
    return x;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < HID; n++) m_c[n] = 0;
    m_g = 0;
    m_u = 0;
  endtask

  task automatic model_accept(input logic [15:0] x);
    int     xv, cn;
    longint s, hp;
    exp_t   e;
    xv = int'($signed(x));
    case (m_g)
      0: m_i  = hsig(xv);
      1: m_f  = hsig(xv);
      2: m_gg = htanh(xv);
      default: begin
        s = longint'(m_f) * longint'(m_c[m_u]) + longint'(m_i) * longint'(m_gg);
        s = s >>> FL;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        cn = int'(s);
        hp = longint'(hsig(xv)) * longint'(htanh(cn));
        hp = hp >>> FL;
        e.h    = hp[15:0];
        e.c    = cn[15:0];
        e.idx  = 8'(m_u);
        e.done = (m_u == HID-1);
        e.cyc  = cyc + 3;
        q.push_back(e);
        m_c[m_u] = cn;
        m_u = (m_u + 1) % HID;
      end
    endcase
    m_g = (m_g + 1) % 4;
  endtask

  task automatic send(input logic [15:0] x);
    in_valid = 1'b1;
    d_in     = x;
    model_accept(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_unit(input logic [15:0] gi, input logic [15:0] gf,
                           input logic [15:0] gg, input logic [15:0] go);
    send(gi); send(gf); send(gg); send(go);
  endtask

  task automatic clear_pulse(input logic with_valid);
    clear_state = 1'b1;
    in_valid    = with_valid;
    d_in        = 16'($urandom);
    model_clear();
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    @(posedge clk); #1;
    clear_state = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    model_clear();
    while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'($urandom_range(0, 16'h1FFF));
      default: return 16'($urandom);
    endcase
  endfunction

  // Monitor: compares each output pulse against the scoreboard head
  logic [15:0] last_h = '0, last_c = '0;
  logic [7:0]  last_idx = '0;
  exp_t        me;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {h_o, c_o, h_idx, o_valid, seq_done}, 64'd0);
      last_h = '0; last_c = '0; last_idx = '0;
    end else if (o_valid) begin
      if (q.size() == 0) begin
        chk("o_valid_unexpected", o_valid, 1'b0);
      end else begin
        me = q.pop_front();
        chk("h_o", h_o, me.h);
        chk("c_o", c_o, me.c);
        chk("h_idx", h_idx, me.idx);
        chk("seq_done", seq_done, me.done);
        chk("latency_cycle", cyc, me.cyc);
      end
      last_h = h_o; last_c = c_o; last_idx = h_idx;
    end else begin
      chk("hold_outputs", {h_o, c_o, h_idx, seq_done}, {last_h, last_c, last_idx, 1'b0});
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        me = q.pop_front();
        chk("o_valid_missing", o_valid, 1'b1);
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; clear_state = 1'b0; d_in = '0;
    model_clear();
    m_i = 0; m_f = 0; m_gg = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // unit 0 from reset, then state carry across two units
    send_unit(16'h7FFF, 16'h0000, 16'h1000, 16'h7FFF);
    idle(4);
    send_unit(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send_unit(16'h7FFF, 16'h7FFF, 16'h1000, 16'h7FFF);
    idle(5);

    // drive c_mem[0] down to -30000, then saturate
    clear_pulse(1'b0);
    for (int k = 0; k < 7; k++) begin
      send_unit(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF);
      send_unit(rnd16(), rnd16(), rnd16(), rnd16());
    end
    send_unit(16'h7FFF, 16'h7FFF, 16'(-1328), 16'h7FFF);
    send_unit(rnd16(), rnd16(), rnd16(), rnd16());
    send_unit(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF);
    idle(5);

    // clear after two gates, with a discarded in_valid in the clear cycle
    send(rnd16()); send(rnd16());
    clear_pulse(1'b1);
    send_unit(16'h7FFF, 16'h7FFF, 16'h1000, 16'h7FFF);
    idle(5);

    // clear one edge after an o gate: that unit must not appear
    send_unit(rnd16(), rnd16(), rnd16(), rnd16());
    clear_pulse(1'b0);
    idle(5);

    // reset at edge k+1 after an o gate
    send_unit(rnd16(), rnd16(), rnd16(), rnd16());
    rst_pulse();
    idle(5);
    send_unit(rnd16(), rnd16(), rnd16(), rnd16());
    idle(5);

    // back-to-back traffic across several sequence wraps
    for (int k = 0; k < 4*HID*3; k++) send(rnd16());
    idle(5);

    // random traffic with gaps
    for (int k = 0; k < 240; k++) begin
      send(rnd16());
      idle($urandom_range(0, 2));
    end
    idle(6);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
